// File: rtl/key_block_encoder_if.sv
// Key block bus: raw push-buttons in, held {valid, code} key block and busy flag out.
interface key_block_encoder_if #(
    parameter int NUM_KEYS = 16
);
    logic [NUM_KEYS-1:0] buttons;
    logic [4:0]          key;
    logic                busy;

    modport master (input buttons, output key, output busy);
    modport slave  (output buttons, input key, input busy);
endinterface

// File: rtl/key_block_encoder.sv
// Source end of the key block: synchronises and debounces raw buttons, then drives
// a held {valid, code} key block that rises exactly once per accepted press.
module key_block_encoder #(
    parameter int NUM_KEYS        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                newClock,
    input  logic                resetN,
    key_block_encoder_if.master bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_RELEASE,
        S_GAP
    } state_t;

    logic [NUM_KEYS-1:0] sync_meta_q;
    logic [NUM_KEYS-1:0] sync_q;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [3:0]          code_q, code_d;
    logic [4:0]          key_q, key_d;
    logic                busy_q, busy_d;

    logic                pressed;
    logic [3:0]          cand;
    logic                match;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        cand = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (sync_q[k]) begin
                cand = 4'(k);
            end
        end
    end

    assign pressed = |sync_q;
    assign match   = pressed && (cand == code_q);

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        code_d  = code_q;
        key_d   = key_q;

        unique case (state_q)
            S_IDLE: begin
                key_d = '0;
                if (pressed) begin
                    code_d  = cand;
                    cnt_d   = '0;
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                key_d = '0;
                if (!match) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    key_d   = {1'b1, code_q};
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                key_d = {1'b1, code_q};
                if (!match) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                key_d = {1'b1, code_q};
                if (match) begin
                    state_d = S_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    key_d   = '0;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                key_d = '0;
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                key_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, including the two synchroniser stages.
    always_ff @(posedge newClock) begin
        if (!resetN) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            code_q      <= '0;
            key_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            sync_meta_q <= bus.buttons;
            sync_q      <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            code_q      <= code_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.key  = key_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_key_block_encoder.sv
// Self-checking bench for key_block_encoder: directed scenarios plus random button
// traces scored cycle by cycle against a sample-stream model of the press rules.
module tb_key_block_encoder;

    localparam int D    = 4;
    localparam int G    = 2;
    localparam int MAXN = 256;

    logic clk;
    logic rst_n;

    key_block_encoder_if #(.NUM_KEYS(16)) bus ();

    key_block_encoder #(
        .NUM_KEYS       (16),
        .DEBOUNCE_CYCLES(D),
        .GAP_CYCLES     (G)
    ) dut (
        .newClock(clk),
        .resetN  (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] stim     [MAXN];
    logic [4:0]  act_key  [MAXN];
    logic [4:0]  exp_key  [MAXN];
    logic        act_busy [MAXN];
    logic        exp_busy [MAXN];

    int passed;
    int total;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int k = 15; k >= 0; k--) if (v[k]) r = 4'(k);
        return r;
    endfunction

    function automatic bit same_key(input logic [15:0] v, input logic [3:0] c);
        return (v != 16'h0) && (lowest(v) == c);
    endfunction

    // The FSM sees each button pattern two edges late. A press is accepted at the
    // (D+1)th consecutive sample showing the same lowest button; a mismatch sample
    // aborts and is consumed. Release needs D+1 consecutive mismatches, then key
    // stays low for G cycles before sampling resumes one edge later.
    task automatic run_model(input int n);
        logic [15:0] s [MAXN];
        logic [3:0]  c;
        int i, j, rise, fall, run;
        for (int e = 0; e < n; e++) begin
            s[e]        = (e >= 2) ? stim[e-2] : 16'h0;
            exp_key[e]  = '0;
            exp_busy[e] = 1'b0;
        end
        i = 0;
        while (i < n) begin
            if (s[i] == 16'h0) begin
                i++;
                continue;
            end
            c = lowest(s[i]);
            j = 1;
            while (j <= D && i + j < n && same_key(s[i+j], c)) j++;
            if (j <= D) begin
                for (int e = i; e < i + j && e < n; e++) exp_busy[e] = 1'b1;
                i = i + j + 1;
                continue;
            end
            rise = i + D;
            fall = n;
            run  = 0;
            for (int k = rise + 1; k < n; k++) begin
                run = same_key(s[k], c) ? 0 : run + 1;
                if (run == D + 1) begin
                    fall = k;
                    break;
                end
            end
            for (int e = i; e < n && e < fall + G; e++) exp_busy[e] = 1'b1;
            for (int e = rise; e < n && e < fall; e++) exp_key[e] = {1'b1, c};
            i = fall + G + 1;
        end
    endtask

    task automatic drive_trace(input int n);
        for (int e = 0; e < n; e++) begin
            @(negedge clk);
            bus.buttons = stim[e];
            @(posedge clk);
            #1;
            act_key[e]  = bus.key;
            act_busy[e] = bus.busy;
        end
        run_model(n);
    endtask

    task automatic apply_reset(input int cycles, input logic [15:0] btn);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.buttons = btn;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int nth_rise(input int n, input int which);
        int cnt;
        cnt = 0;
        for (int e = 0; e < n; e++) begin
            if (act_key[e][4] && (e == 0 || !act_key[e-1][4])) begin
                if (cnt == which) return e;
                cnt++;
            end
        end
        return -1;
    endfunction

    function automatic int count_rises(input int n);
        int cnt;
        cnt = 0;
        for (int e = 0; e < n; e++)
            if (act_key[e][4] && (e == 0 || !act_key[e-1][4])) cnt++;
        return cnt;
    endfunction

    function automatic int first_low_after(input int n, input int from);
        for (int e = from; e < n; e++) if (!act_key[e][4]) return e;
        return -1;
    endfunction

    task automatic test_reset();
        int r;
        rst_n       = 1'b0;
        bus.buttons = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.key !== 5'b0 || bus.busy !== 1'b0)
                $display("FAIL reset_hold edge%0d key=%h busy=%b expected key=00 busy=0",
                         k, bus.key, bus.busy);
            else passed++;
        end
        rst_n = 1'b1;
        for (int e = 0; e < 14; e++) stim[e] = 16'hFFFF;
        drive_trace(14);
        for (int e = 0; e < 14; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL reset_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        r = nth_rise(14, 0);
        total++;
        if (r !== D + 2) $display("FAIL reset_latency rise=%0d expected %0d", r, D + 2);
        else passed++;
        total++;
        if (r < 0 || act_key[r] !== 5'h10)
            $display("FAIL reset_code key=%h expected 10", (r < 0) ? 5'h0 : act_key[r]);
        else passed++;
    endtask

    task automatic test_single_press();
        int r, f;
        apply_reset(2, 16'h0);
        for (int e = 0; e < 52; e++) stim[e] = (e >= 2 && e < 32) ? 16'h0020 : 16'h0;
        drive_trace(52);
        for (int e = 0; e < 52; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL single_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        r = nth_rise(52, 0);
        f = (r < 0) ? -1 : first_low_after(52, r);
        total++;
        if (count_rises(52) !== 1)
            $display("FAIL single_rises got %0d expected 1", count_rises(52));
        else passed++;
        total++;
        if (r !== 2 + D + 2 || act_key[r] !== 5'h15)
            $display("FAIL single_rise edge=%0d expected %0d code 15", r, 2 + D + 2);
        else passed++;
        total++;
        if (f !== 32 + 2 + D) $display("FAIL single_fall edge=%0d expected %0d", f, 32 + 2 + D);
        else passed++;
    endtask

    task automatic test_bounce();
        int r;
        apply_reset(2, 16'h0);
        for (int e = 0; e < 40; e++)
            stim[e] = (e >= 12 || ((e / 2) % 2) == 0) ? 16'h0008 : 16'h0;
        drive_trace(40);
        for (int e = 0; e < 40; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL bounce_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        r = nth_rise(40, 0);
        total++;
        if (r !== 12 + D + 2 || act_key[r] !== 5'h13 || count_rises(40) !== 1)
            $display("FAIL bounce_rise edge=%0d rises=%0d expected edge %0d code 13 one rise",
                     r, count_rises(40), 12 + D + 2);
        else passed++;
    endtask

    task automatic test_code_change();
        int r0, r1, f0;
        apply_reset(2, 16'h0);
        for (int e = 0; e < 75; e++)
            stim[e] = (e < 25) ? 16'h0204 : (e < 60) ? 16'h0200 : 16'h0;
        drive_trace(75);
        for (int e = 0; e < 75; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL change_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        r0 = nth_rise(75, 0);
        r1 = nth_rise(75, 1);
        f0 = (r0 < 0) ? -1 : first_low_after(75, r0);
        total++;
        if (count_rises(75) !== 2 || r0 < 0 || r1 < 0 || act_key[r0] !== 5'h12 || act_key[r1] !== 5'h19)
            $display("FAIL change_codes rises=%0d expected 2 with codes 12 then 19", count_rises(75));
        else passed++;
        total++;
        if (f0 < 0 || r1 - f0 < G)
            $display("FAIL change_gap low=%0d expected >= %0d", r1 - f0, G);
        else passed++;
    endtask

    task automatic test_glitch();
        int r;
        apply_reset(2, 16'h0);
        for (int e = 0; e < 40; e++)
            stim[e] = ((e >= 2 && e < 5) || e >= 15) ? 16'h8000 : 16'h0;
        drive_trace(40);
        for (int e = 0; e < 40; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL glitch_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        r = nth_rise(40, 0);
        total++;
        if (r !== 15 + D + 2 || act_key[r] !== 5'h1F)
            $display("FAIL glitch_rise edge=%0d expected %0d code 1f", r, 15 + D + 2);
        else passed++;
    endtask

    task automatic test_reset_held();
        apply_reset(2, 16'h0);
        for (int e = 0; e < 20; e++) stim[e] = 16'h0080;
        drive_trace(20);
        total++;
        if (act_key[19] !== 5'h17 || nth_rise(20, 0) !== D + 2)
            $display("FAIL held_before key=%h rise=%0d expected 17 at %0d",
                     act_key[19], nth_rise(20, 0), D + 2);
        else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.key !== 5'b0 || bus.busy !== 1'b0)
            $display("FAIL held_reset key=%h busy=%b expected key=00 busy=0", bus.key, bus.busy);
        else passed++;
        rst_n = 1'b1;
        drive_trace(20);
        for (int e = 0; e < 20; e++) begin
            total++;
            if (act_key[e] !== exp_key[e] || act_busy[e] !== exp_busy[e])
                $display("FAIL held_trace cyc%0d key=%h busy=%b expected key=%h busy=%b",
                         e, act_key[e], act_busy[e], exp_key[e], exp_busy[e]);
            else passed++;
        end
        total++;
        if (count_rises(20) !== 1 || nth_rise(20, 0) !== D + 2)
            $display("FAIL held_repeat rises=%0d rise=%0d expected 1 at %0d",
                     count_rises(20), nth_rise(20, 0), D + 2);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] pat;
        int e, len;
        for (int run = 0; run < 5; run++) begin
            apply_reset(2, 16'h0);
            e   = 0;
            pat = 16'h0;
            while (e < 200) begin
                case ($urandom_range(0, 3))
                    0:       pat = 16'h0;
                    1:       pat = 16'h1 << $urandom_range(0, 15);
                    2:       pat = 16'($urandom);
                    default: pat = pat ^ (16'h1 << $urandom_range(0, 15));
                endcase
                len = $urandom_range(1, 12);
                for (int k = 0; k < len && e < 200; k++) begin
                    stim[e] = pat;
                    e++;
                end
            end
            drive_trace(200);
            for (int c = 0; c < 200; c++) begin
                total++;
                if (act_key[c] !== exp_key[c] || act_busy[c] !== exp_busy[c])
                    $display("FAIL random%0d cyc%0d key=%h busy=%b expected key=%h busy=%b",
                             run, c, act_key[c], act_busy[c], exp_key[c], exp_busy[c]);
                else passed++;
            end
        end
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst_n       = 1'b0;
        bus.buttons = 16'h0;
        test_reset();
        test_single_press();
        test_bounce();
        test_code_change();
        test_glitch();
        test_reset_held();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
